// File: rtl/mm_seq_pkg.sv
`default_nettype none
// ============================================================================
// mm_seq_pkg : CSR map, CTRL/STATUS bit positions and FSM encoding
// Revision   : 1.0
// ============================================================================
package mm_seq_pkg;

   localparam logic [4:0] c_off_ctrl   = 5'h00;
   localparam logic [4:0] c_off_status = 5'h04;
   localparam logic [4:0] c_off_src    = 5'h08;
   localparam logic [4:0] c_off_dst    = 5'h0C;
   localparam logic [4:0] c_off_mmbase = 5'h10;
   localparam logic [4:0] c_off_len    = 5'h14;
   localparam logic [4:0] c_off_resoff = 5'h18;
   localparam logic [4:0] c_off_rlen   = 5'h1C;

   localparam int c_ctrl_start   = 0;
   localparam int c_ctrl_abort   = 1;
   localparam int c_stat_busy    = 0;
   localparam int c_stat_done    = 1;
   localparam int c_stat_aborted = 2;
   localparam int c_stat_idx_lsb = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LD_RD = 3'd1,
      ST_LD_WR = 3'd2,
      ST_RS_RD = 3'd3,
      ST_RS_WR = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mm_seq_ctrl : CSR-programmed load/result word sequencer over a memory master
// Revision    : 1.0
// ============================================================================
module mm_seq_ctrl
   import mm_seq_pkg::*;
#(
   parameter int LEN_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_valid,
   input  logic [4:0]  csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic [3:0]  csr_wstrb,
   output logic [31:0] csr_rdata,
   output logic        csr_ready,
   output logic        m_valid,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic [31:0] m_rdata,
   input  logic        m_ready,
   output logic        done
);

   logic [31:0]      r_src, r_dst, r_mmbase, r_resoff, r_data;
   logic [LEN_W-1:0] r_len, r_rlen, r_idx, w_idx_inc;
   state_t           r_state, w_next;
   logic             r_gap, r_abort_pend, r_done, r_aborted;
   logic             w_wr, w_busy, w_start, w_abort, w_clr_done, w_clr_abt;
   logic             w_xfer, w_is_wr, w_mv, w_hs, w_abort_fire;
   logic [31:0]      w_base, w_status;

   assign w_wr       = csr_valid && (csr_wstrb != 4'h0);
   assign w_busy     = (r_state != ST_IDLE);
   assign w_start    = w_wr && (csr_addr == c_off_ctrl) && csr_wdata[c_ctrl_start]
                       && !csr_wdata[c_ctrl_abort] && !w_busy;
   assign w_abort    = w_wr && (csr_addr == c_off_ctrl) && csr_wdata[c_ctrl_abort] && w_busy;
   assign w_clr_done = w_wr && (csr_addr == c_off_status) && csr_wdata[c_stat_done];
   assign w_clr_abt  = w_wr && (csr_addr == c_off_status) && csr_wdata[c_stat_aborted];
   assign csr_ready  = csr_valid;
   assign done       = r_done;

   always_comb begin
      w_status                          = '0;
      w_status[c_stat_busy]             = w_busy;
      w_status[c_stat_done]             = r_done;
      w_status[c_stat_aborted]          = r_aborted;
      w_status[c_stat_idx_lsb +: 16]    = 16'(r_idx);
   end

   // CTRL is pulse-only and reads back as zero
   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         c_off_status: csr_rdata = w_status;
         c_off_src:    csr_rdata = r_src;
         c_off_dst:    csr_rdata = r_dst;
         c_off_mmbase: csr_rdata = r_mmbase;
         c_off_len:    csr_rdata = 32'(r_len);
         c_off_resoff: csr_rdata = r_resoff;
         c_off_rlen:   csr_rdata = 32'(r_rlen);
         default:      csr_rdata = '0;
      endcase
   end

   // Config stays frozen during a run, so the live registers act as the run's snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_mmbase <= '0;
         r_resoff <= '0;
         r_len    <= '0;
         r_rlen   <= '0;
      end else if (w_wr && !w_busy) begin
         case (csr_addr)
            c_off_src:    r_src    <= merge_bytes(r_src, csr_wdata, csr_wstrb);
            c_off_dst:    r_dst    <= merge_bytes(r_dst, csr_wdata, csr_wstrb);
            c_off_mmbase: r_mmbase <= merge_bytes(r_mmbase, csr_wdata, csr_wstrb);
            c_off_resoff: r_resoff <= merge_bytes(r_resoff, csr_wdata, csr_wstrb);
            c_off_len:    r_len    <= csr_wdata[LEN_W-1:0];
            c_off_rlen:   r_rlen   <= csr_wdata[LEN_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      w_xfer    = r_state inside {ST_LD_RD, ST_LD_WR, ST_RS_RD, ST_RS_WR};
      w_is_wr   = (r_state == ST_LD_WR) || (r_state == ST_RS_WR);
      w_mv      = w_xfer && !r_gap;
      w_hs      = w_mv && m_ready;
      w_idx_inc = r_idx + 1'b1;
      w_base    = '0;
      case (r_state)
         ST_IDLE:
            if (w_start)
               w_next = (r_len != '0) ? ST_LD_RD : (r_rlen != '0) ? ST_RS_RD : ST_FIN;
         ST_LD_RD: begin
            w_base = r_src;
            if (w_hs) w_next = ST_LD_WR;
         end
         ST_LD_WR: begin
            w_base = r_mmbase;
            if (w_hs)
               w_next = (w_idx_inc < r_len) ? ST_LD_RD : (r_rlen != '0) ? ST_RS_RD : ST_FIN;
         end
         ST_RS_RD: begin
            w_base = r_mmbase + r_resoff;
            if (w_hs) w_next = ST_RS_WR;
         end
         ST_RS_WR: begin
            w_base = r_dst;
            if (w_hs) w_next = (w_idx_inc < r_rlen) ? ST_RS_RD : ST_FIN;
         end
         ST_FIN:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      // An abort waits only for a transfer whose valid is already up
      w_abort_fire = (w_abort || r_abort_pend) && (!w_mv || w_hs);
      if (w_abort_fire) w_next = ST_IDLE;
      m_valid = w_mv;
      m_addr  = w_mv ? ((w_base + (32'(r_idx) << 2)) & ~32'h3) : '0;
      m_wstrb = (w_mv && w_is_wr) ? 4'hF : 4'h0;
      m_wdata = (w_mv && w_is_wr) ? r_data : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_gap        <= 1'b0;
         r_abort_pend <= 1'b0;
         r_data       <= '0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_gap   <= w_hs;
         if (w_next == ST_IDLE)
            r_abort_pend <= 1'b0;
         else if (w_abort)
            r_abort_pend <= 1'b1;
         if (w_hs && !w_is_wr)
            r_data <= m_rdata;
         if (w_start)
            r_idx <= '0;
         else if (w_hs && w_is_wr)
            r_idx <= ((r_state == ST_LD_WR) && !(w_idx_inc < r_len)) ? '0 : w_idx_inc;
         if ((r_state == ST_FIN) && !w_abort_fire)
            r_done <= 1'b1;
         else if (w_start || w_clr_done)
            r_done <= 1'b0;
         if (w_abort_fire)
            r_aborted <= 1'b1;
         else if (w_start || w_clr_abt)
            r_aborted <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: doc/mm_seq_ctrl.md
MM_SEQ_CTRL -- requirements
Module: mm_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 10: width of the word-count registers; max transfer is 2^LEN_W-1 words.
REQ-002 SHALL have ports clk in 1 (single clock, rising edge) and rst in 1 (asynchronous, active-high reset).
REQ-003 SHALL have CSR slave inputs: csr_valid in 1; csr_addr in 5 (byte offset); csr_wdata in 32; csr_wstrb in 4 (0 means read).
REQ-004 SHALL have CSR slave outputs: csr_rdata out 32; csr_ready out 1.
REQ-005 SHALL have memory master outputs: m_valid out 1; m_addr out 32; m_wdata out 32; m_wstrb out 4 (0 means read).
REQ-006 SHALL have memory master inputs: m_rdata in 32; m_ready in 1.
REQ-007 SHALL have port done out 1: level copy of STATUS.done.

Function
REQ-008 SHALL decode CSR offsets: 0x00 CTRL; 0x04 STATUS; 0x08 SRC; 0x0C DST; 0x10 MMBASE; 0x14 LEN; 0x18 RESOFF; 0x1C RLEN.
REQ-009 SHALL treat CTRL bits as write-1 pulses: bit0 start, bit1 abort.
REQ-010 SHALL define STATUS bits: bit0 busy (RO), bit1 done (W1C), bit2 aborted (W1C); bits [31:16] = current word index (RO).
REQ-011 SHALL honour byte strobes on SRC, DST, MMBASE and RESOFF writes; LEN and RLEN SHALL use only wdata[LEN_W-1:0] and read back zero-extended.
REQ-012 SHALL assert csr_ready combinationally in the same cycle as csr_valid, with csr_rdata combinational; unmapped offsets SHALL read 0 and ignore writes.
REQ-013 SHALL force m_addr[1:0] to 0 and use 32-bit address arithmetic that wraps modulo 2^32.
REQ-014 SHALL implement states IDLE, LD_RD, LD_WR, RS_RD, RS_WR, FIN.
REQ-015 SHALL, on start in IDLE, latch all config registers, clear done/aborted, set idx=0, and go to LD_RD if LEN!=0, else RS_RD if RLEN!=0, else FIN.
REQ-016 LD_RD SHALL issue read SRC+4*idx; on m_ready capture m_rdata and go to LD_WR.
REQ-017 LD_WR SHALL issue write MMBASE+4*idx with wstrb 4'hF and the captured data; on m_ready increment idx, stay in the load loop while idx<LEN, else set idx=0 and go to RS_RD (if RLEN!=0) or FIN.
REQ-018 RS_RD SHALL read MMBASE+RESOFF+4*idx; RS_WR SHALL write DST+4*idx; the loop SHALL run for RLEN words, then go to FIN.
REQ-019 FIN SHALL set done for one cycle of state, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-020 SHALL raise m_valid only in the four transfer states and hold m_valid, m_addr, m_wdata and m_wstrb stable until the m_ready cycle.
REQ-021 SHALL deassert m_valid for at least one cycle after each accepted transfer (no back-to-back valid), giving 2 cycles minimum per transaction.
REQ-022 SHALL ignore start while busy; SHALL ignore config writes while busy (registers keep their values).
REQ-023 SHALL, on abort while busy, complete the in-flight transaction (valid already high), then enter IDLE with aborted=1 and done=0; abort in IDLE SHALL be ignored.
REQ-024 SHALL give precedence to abort when start and abort are written together.
REQ-025 SHALL give the hardware set precedence when a done W1C write coincides with the FIN set.

Reset
REQ-026 SHALL, on rst asserted, asynchronously enter IDLE and clear all config registers, idx, done and aborted.
REQ-027 SHALL drive m_valid=0, m_wstrb=0, m_addr=0, m_wdata=0, done=0 and csr_ready=csr_valid while in reset.
REQ-028 SHALL, on reset mid-transfer, drop m_valid immediately with no completion guarantee; software re-programs.

Structure
REQ-029 SHALL place the CSR offsets, CTRL/STATUS bit positions and state encoding in shared package mm_seq_pkg.
REQ-030 SHALL be implemented as a single module with no sub-modules; the CSR decode and the FSM/datapath are kept as separate always blocks.

Verification
REQ-031 SHALL verify a basic run: SRC=0x100, MMBASE=0x03000000, LEN=4, RESOFF=0x40, RLEN=2, DST=0x200, start -> 4 read/write pairs, then 2 pairs reading 0x03000040/44 and writing 0x200/0x204, done=1, 12 transactions total.
REQ-032 SHALL verify LEN=0, RLEN=0: start -> FIN in the next cycle, done=1, m_valid never asserted.
REQ-033 SHALL verify m_ready stalled 5 cycles on every transfer -> m_addr/m_wdata stable throughout, results identical to REQ-031.
REQ-034 SHALL verify abort during LD_WR of idx=2 -> that write completes, no further m_valid, aborted=1, done=0, busy=0.
REQ-035 SHALL verify SRC=0xFFFFFFF8, LEN=3 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
REQ-036 SHALL verify rst asserted mid RS_RD -> m_valid=0 asynchronously and all CSRs read 0 after rst deasserts.
